jstk2_spi_responder: RTL
========================

// Module: jstk2_spi_responder
// PURPOSE
//  SPI slave (responder) end of the JSTK2 joystick link: emulates the PmodJSTK2 so the
//  JSTK2 SPI master, the Steering_X/Steering_Y servo path and the debug display can run
//  on-board or in simulation without the physical Pmod. Serves a 5-byte position/button
//  frame on MISO per SS-low window; captures the master's MOSI bytes.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages on SS/SCLK/MOSI inputs (>=2)
//  NUM_BYTES    5  bytes per frame served before MISO idles at 0
// PORTS
//  clk         in   1   system clock (100 MHz)
//  rst         in   1   asynchronous, active-low reset
//  ss          in   1   slave select from master, active-low, asynchronous to clk
//  sclk        in   1   SPI clock from master (mode 0), asynchronous to clk
//  mosi        in   1   master-out data
//  miso        out  1   slave-out data, MSB first
//  x_pos       in   10  joystick X to report, 0..1023
//  y_pos       in   10  joystick Y to report, 0..1023
//  buttons     in   2   {trigger, stick} button states
//  cmd         out  8   first MOSI byte of last completed frame
//  cmd_valid   out  1   1-clk pulse, cmd updated
//  busy        out  1   high while a frame is in progress
//  frame_done  out  1   1-clk pulse, >=40 bits clocked, then SS released
//  frame_err   out  1   1-clk pulse, SS released before 40 bits
//  led_rgb     out  24  {R,G,B} from LED command (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0): miso=0, cmd=0, cmd_valid=0, busy=0, frame_done=0, frame_err=0,
//    led_rgb=0, FSM=IDLE, sync chains cleared to idle (ss=1, sclk=0, mosi=0).
//  - Inputs pass SYNC_STAGES FFs plus 1 edge-detect FF; event latency SYNC_STAGES+1 clk.
//    Master SCLK half-period must be >= SYNC_STAGES+3 clk cycles (>=5 clk at default).
//  - Mode 0: MOSI sampled on synced SCLK rise; MISO changes on synced SCLK fall.
//  - Frame bytes: b0=x[7:0], b1={6'b0,x[9:8]}, b2=y[7:0], b3={6'b0,y[9:8]},
//    b4={6'b0,buttons}. x/y/buttons snapshotted at SS fall; changes mid-frame not seen.
//  - FSM: IDLE -(SS fall)-> SHIFT: snapshot, load b0, miso=b0[7], bit_cnt=0, busy=1.
//    SHIFT: each rise: rx<={rx[6:0],mosi}, bit_cnt++; at bit_cnt==8 first time latch cmd.
//    Each fall: next bit to miso; after 8th bit of byte n load byte n+1 MSB.
//    bit_cnt saturates at 8*NUM_BYTES; beyond that miso=0 and extra edges ignored.
//    SHIFT -(SS rise)-> DONE: frame_done if bit_cnt==8*NUM_BYTES, else frame_err;
//    cmd_valid if >=8 bits received. DONE -> IDLE next clk, busy=0, miso=0.
//  - SS high: miso held 0 (no internal tri-state), SCLK/MOSI edges ignored.
//  - SS fall while in DONE: taken on following clk (edge held one cycle); no frame lost.
//  - SCLK rise and fall same synced cycle impossible by timing rule; no handling needed.
//  - Reset mid-frame: immediate return to IDLE, all outputs to reset values.
// CONFIGURATION
//  JSTK2_LED_CMD_EN defined: if cmd==8'h84, MOSI bytes 1..3 latched to led_rgb as
//    {R,G,B} at frame_done only (frame_err leaves led_rgb unchanged).
//  Undefined: led_rgb tied 24'h0, only first MOSI byte captured; LED logic absent.
// TESTING
//  1 x=10'h2A5,y=10'h0F3,buttons=2'b10, 40-bit frame at SCLK=1 MHz, MOSI=8'h00
//    -> MISO bytes A5,02,F3,00,02; frame_done=1 pulse; cmd=00, cmd_valid pulse.
//  2 SS released after 12 bits -> frame_err pulse, no frame_done; cmd_valid pulse; next
//    frame starts from b0 again.
//  3 x changes 10'h000->10'h3FF after byte 0 -> frame still reports 00,00; next frame FF,03.
//  4 48 SCLK cycles in one SS window -> bits 41..48 MISO=0, frame_done single pulse.
//  5 rst=0 asserted at bit 20 -> busy=0, miso=0 within 1 clk; next frame correct.
//  6 JSTK2_LED_CMD_EN: MOSI 84,FF,10,01,00 -> led_rgb=24'hFF1001 after SS rise;
//    same with cmd=8'hC0 -> led_rgb unchanged; macro undefined -> led_rgb=0 always.

Source files
------------

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2 emulator: SPI mode-0 responder serving a 5-byte X/Y/button frame and capturing MOSI.
// Optional macro JSTK2_LED_CMD_EN: command 8'h84 loads MOSI bytes 1..3 into led_rgb at frame_done.
module jstk2_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [1:0]  buttons,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [23:0] led_rgb
);

  localparam int NBITS = 8 * NUM_BYTES;
  localparam int CW    = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_s, sclk_s, mosi_s;
  logic                   ss_d, sclk_d;
  logic                   ss_q, sclk_q, mosi_q;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic                   fall_pend;
  logic [CW-1:0]          bit_cnt;
  logic [39:0]            base;
  logic [39:0]            tx_sh;
  logic [6:0]             rx;
  logic [7:0]             rx_byte;

  assign ss_q      = ss_s[SYNC_STAGES-1];
  assign sclk_q    = sclk_s[SYNC_STAGES-1];
  assign mosi_q    = mosi_s[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_q;
  assign ss_rise   = ~ss_d & ss_q;
  assign sclk_rise = ~sclk_d & sclk_q;
  assign sclk_fall = sclk_d & ~sclk_q;
  assign rx_byte   = {rx, mosi_q};

  assign base = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 6'b0, buttons};

  // Synchronisers reset to the idle bus state so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_s   <= '1;
      sclk_s <= '0;
      mosi_s <= '0;
      ss_d   <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ss_s   <= {ss_s[SYNC_STAGES-2:0], ss};
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      ss_d   <= ss_q;
      sclk_d <= sclk_q;
    end
  end

`ifdef JSTK2_LED_CMD_EN
  logic [23:0] led_sh;
`else
  assign led_rgb = 24'h0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      miso       <= 1'b0;
      cmd        <= 8'h00;
      cmd_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      fall_pend  <= 1'b0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx         <= '0;
`ifdef JSTK2_LED_CMD_EN
      led_sh     <= '0;
      led_rgb    <= '0;
`endif
    end else begin
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (ss_fall || fall_pend) begin
            fall_pend <= 1'b0;
            state     <= SHIFT;
            tx_sh     <= {base[38:0], 1'b0};
            miso      <= base[39];
            bit_cnt   <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= DONE;
            miso  <= 1'b0;
            if (bit_cnt == CW'(NBITS)) frame_done <= 1'b1;
            else                       frame_err  <= 1'b1;
            if (bit_cnt >= CW'(8)) cmd_valid <= 1'b1;
`ifdef JSTK2_LED_CMD_EN
            if (bit_cnt == CW'(NBITS) && cmd == 8'h84) led_rgb <= led_sh;
`endif
          end else if (sclk_rise && bit_cnt != CW'(NBITS)) begin
            rx      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) cmd <= rx_byte;
`ifdef JSTK2_LED_CMD_EN
            if (bit_cnt == CW'(15) || bit_cnt == CW'(23) || bit_cnt == CW'(31))
              led_sh <= {led_sh[15:0], rx_byte};
`endif
          end else if (sclk_fall) begin
            // Zeros shift in behind the frame, so anything past the last byte reads as 0.
            if (bit_cnt == CW'(NBITS)) begin
              miso <= 1'b0;
            end else begin
              miso  <= tx_sh[39];
              tx_sh <= {tx_sh[38:0], 1'b0};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          miso  <= 1'b0;
          if (ss_fall) fall_pend <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
